mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 90 +++++++++
 tb/tb_mem_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: fixed-priority (FPGA > data > instruction) sharing of one sync-read single-port RAM
// Ports: clk/nrst (sync active-low reset); f_* FPGA loader (level req, ready pulse);
// d_* CPU data (d_wen wins over d_ren); i_* instruction fetch (read only);
// ram_* word-addressed RAM port (rdata one cycle after addr); busy = not IDLE; misalign sticky.
module mem_arbiter (
    input  logic        clk,
    input  logic        nrst,
    input  logic        f_req,
    input  logic        f_wen,
    input  logic [31:0] f_addr,
    input  logic [31:0] f_wdata,
    output logic [31:0] f_rdata,
    output logic        f_ready,
    input  logic        d_ren,
    input  logic        d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    output logic [11:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic        ram_wen,
    input  logic [31:0] ram_rdata,
    output logic        busy,
    output logic        misalign
);
    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_F, OWN_D, OWN_I} owner_t;

    state_t      state, state_nx;
    owner_t      owner, sel_owner;
    logic        wr, sel_wr, d_any, grant;
    logic [13:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        unused_addr_hi;

    // Only a 16 KiB window is decoded; upper address bits wrap.
    assign unused_addr_hi = ^{f_addr[31:14], d_addr[31:14], i_addr[31:14]};

    always_comb begin
        d_any     = d_ren | d_wen;
        grant     = f_req | d_any | i_req;
        sel_owner = f_req ? OWN_F : d_any ? OWN_D : i_req ? OWN_I : OWN_NONE;
        sel_addr  = f_req ? f_addr[13:0] : d_any ? d_addr[13:0] : i_addr[13:0];
        sel_wdata = f_req ? f_wdata : d_any ? d_wdata : 32'd0;
        sel_wr    = f_req ? f_wen : d_any ? d_wen : 1'b0;
        state_nx  = state == IDLE    ? (grant ? ACCESS : IDLE) :
                    state == ACCESS  ? (wr ? DONE : CAPTURE) :
                    state == CAPTURE ? DONE : IDLE;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state     <= IDLE;
            owner     <= OWN_NONE;
            wr        <= 1'b0;
            ram_addr  <= 12'd0;
            ram_wdata <= 32'd0;
            misalign  <= 1'b0;
            f_rdata   <= 32'd0;
            d_rdata   <= 32'd0;
            i_rdata   <= 32'd0;
        end else begin
            state <= state_nx;
            if (state == IDLE && grant) begin
                owner     <= sel_owner;
                wr        <= sel_wr;
                ram_addr  <= sel_addr[13:2];
                ram_wdata <= sel_wdata;
                misalign  <= misalign | (sel_addr[1:0] != 2'd0);
            end
            if (state == CAPTURE) begin
                f_rdata <= owner == OWN_F ? ram_rdata : f_rdata;
                d_rdata <= owner == OWN_D ? ram_rdata : d_rdata;
                i_rdata <= owner == OWN_I ? ram_rdata : i_rdata;
            end
        end
    end

    // Gating with nrst kills the write strobe in the very cycle reset is applied.
    assign ram_wen = nrst & (state == ACCESS) & wr;
    assign busy    = state != IDLE;
    assign f_ready = (state == DONE) & (owner == OWN_F);
    assign d_ready = (state == DONE) & (owner == OWN_D);
    assign i_ready = (state == DONE) & (owner == OWN_I);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural sync-read RAM
module tb_mem_arbiter;
    logic        clk = 0, nrst = 0;
    logic        f_req = 0, f_wen = 0, f_ready;
    logic [31:0] f_addr = 0, f_wdata = 0, f_rdata;
    logic        d_ren = 0, d_wen = 0, d_ready;
    logic [31:0] d_addr = 0, d_wdata = 0, d_rdata;
    logic        i_req = 0, i_ready;
    logic [31:0] i_addr = 0, i_rdata;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic        ram_wen, busy, misalign;

    mem_arbiter dut (
        .clk(clk), .nrst(nrst),
        .f_req(f_req), .f_wen(f_wen), .f_addr(f_addr), .f_wdata(f_wdata), .f_rdata(f_rdata), .f_ready(f_ready),
        .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wen(ram_wen), .ram_rdata(ram_rdata),
        .busy(busy), .misalign(misalign)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [4096];
    logic        preload = 1;
    int          cyc = 0;
    int          checks = 0, failures = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (preload) begin
            for (int k = 0; k < 4096; k++) mem[k] <= (k == 1) ? 32'h00500093 : 32'd0;
        end else if (ram_wen) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        int          who;
        logic        chk;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rd(int w);
        return w == 0 ? f_rdata : w == 1 ? d_rdata : i_rdata;
    endfunction

    task automatic push(int who, logic chk, logic [31:0] data, int due);
        exp_t e;
        e.who = who; e.chk = chk; e.data = data; e.due = due;
        sb.push_back(e);
    endtask

    logic [2:0] rdy;
    exp_t       got_e;
    always @(negedge clk) begin
        rdy = {i_ready, d_ready, f_ready};
        if (rdy != 3'b000) begin
            check("ready_onehot", $countones(rdy), 1);
            for (int w = 0; w < 3; w++) begin
                if (rdy[w]) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_ready who=%0d cyc=%0d", w, cyc);
                    end else begin
                        got_e = sb.pop_front();
                        check("ready_who", w, got_e.who);
                        check("ready_cycle", cyc, got_e.due);
                        if (got_e.chk) check("rdata", rd(w), got_e.data);
                    end
                end
            end
        end
    end

    task automatic drive(int who, logic wr, logic [31:0] a, logic [31:0] w);
        case (who)
            0: begin f_req = 1; f_wen = wr; f_addr = a; f_wdata = w; end
            1: begin d_wen = wr; d_ren = !wr; d_addr = a; d_wdata = w; end
            default: begin i_req = 1; i_addr = a; end
        endcase
    endtask

    task automatic drop(int who);
        case (who)
            0: f_req = 0;
            1: begin d_ren = 0; d_wen = 0; end
            default: i_req = 0;
        endcase
    endtask

    task automatic wait_ready(int who);
        bit got = 0;
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge clk);
            if ((who == 0 && f_ready) || (who == 1 && d_ready) || (who == 2 && i_ready)) got = 1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout who=%0d cyc=%0d", who, cyc);
        end
        drop(who);
    endtask

    task automatic simple(int who, logic wr, logic [31:0] a, logic [31:0] w, logic [31:0] exp);
        @(negedge clk);
        drive(who, wr, a, w);
        push(who, !wr, exp, cyc + (wr ? 2 : 3));
        wait_ready(who);
    endtask

    int g;
    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ram_wen", ram_wen, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_misalign", misalign, 0);
        check("rst_readys", {f_ready, d_ready, i_ready}, 0);
        check("rst_f_rdata", f_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_i_rdata", i_rdata, 0);
        nrst = 1;
        preload = 0;

        @(negedge clk);
        drive(1, 1, 32'h10, 32'hDEADBEEF);
        g = cyc;
        push(1, 0, 0, g + 2);
        @(negedge clk);
        check("wr_ram_wen", ram_wen, 1);
        check("wr_ram_addr", ram_addr, 4);
        check("wr_ram_wdata", ram_wdata, 32'hDEADBEEF);
        check("wr_busy", busy, 1);
        wait_ready(1);
        check("wr_d_rdata_hold", d_rdata, 0);

        @(negedge clk);
        drive(1, 0, 32'h10, 0);
        g = cyc;
        push(1, 1, 32'hDEADBEEF, g + 3);
        @(negedge clk);
        check("rd_ram_wen", ram_wen, 0);
        wait_ready(1);

        simple(2, 0, 32'h4, 0, 32'h00500093);
        check("fetch_f_hold", f_rdata, 0);
        check("fetch_d_hold", d_rdata, 32'hDEADBEEF);

        @(negedge clk);
        drive(0, 1, 32'h20, 32'h11111111);
        drive(1, 1, 32'h24, 32'h22222222);
        drive(2, 0, 32'h20, 0);
        g = cyc;
        push(0, 0, 0, g + 2);
        push(1, 0, 0, g + 5);
        push(2, 1, 32'h11111111, g + 9);
        fork
            wait_ready(0);
            wait_ready(1);
            wait_ready(2);
            begin repeat (3) @(negedge clk); check("gap_idle", busy, 0); end
        join
        simple(1, 0, 32'h24, 0, 32'h22222222);
        simple(0, 0, 32'h20, 0, 32'h11111111);

        @(negedge clk);
        drive(1, 1, 32'h4006, 32'hCAFEF00D);
        g = cyc;
        push(1, 0, 0, g + 2);
        @(negedge clk);
        check("mis_ram_addr", ram_addr, 1);
        check("mis_flag", misalign, 1);
        check("mis_ram_wen", ram_wen, 1);
        wait_ready(1);
        simple(2, 0, 32'h4, 0, 32'hCAFEF00D);
        check("mis_sticky", misalign, 1);

        @(negedge clk);
        drive(1, 1, 32'h30, 32'h55);
        @(negedge clk);
        check("rst_pre_wen", ram_wen, 1);
        nrst = 0;
        #1 check("rst_wen_kill", ram_wen, 0);
        @(negedge clk);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_addr", ram_addr, 0);
        check("rst_mid_wdata", ram_wdata, 0);
        check("rst_mid_misalign", misalign, 0);
        check("rst_mid_rdata", f_rdata | d_rdata | i_rdata, 0);
        @(negedge clk);
        check("rst_no_grant", busy, 0);
        drop(1);
        check("rst_no_write", mem[12], 0);
        nrst = 1;
        simple(1, 0, 32'h10, 0, 32'hDEADBEEF);

        @(negedge clk);
        drive(2, 0, 32'h10, 0);
        g = cyc;
        push(2, 1, 32'hDEADBEEF, g + 3);
        @(negedge clk);
        i_req = 0;
        wait_ready(2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("withdrawn_idle", busy, 0);
        end
        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
